// File: rtl/riscv_pkg.sv
// Shared execute-stage definitions: ALU opcodes, forward-select enum, helpers.
// Operand forwarding is compiled in only when FORWARD_EN is defined.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SQUASH_LEN = 2'd2;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  // M wins over W; loads in M are not forwardable yet.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       m_from_mem,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    if (m_we && !m_from_mem && m_rd != 5'd0 && m_rd == rs)
      return FWD_M;
    if (w_we && w_rd != 5'd0 && w_rd == rs)
      return FWD_W;
    return FWD_NONE;
  endfunction

  function automatic logic [31:0] fwd_mux(
    input fwd_sel_e    sel,
    input logic [31:0] rf,
    input logic [31:0] m,
    input logic [31:0] w
  );
    logic [31:0] r;
    r = rf;
    unique case (sel)
      FWD_M:   r = m;
      FWD_W:   r = w;
      default: r = rf;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU; zero reflects the subtract result for branch compare.
// Unused opcodes produce 0.
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_result,
  output logic        o_zero
);

  logic [31:0] w_diff;
  logic        w_slt;

  assign w_diff = i_a - i_b;
  assign w_slt  = $signed(i_a) < $signed(i_b);
  assign o_zero = (w_diff == 32'd0);

  always_comb begin
    o_result = 32'd0;
    unique case (1'b1)
      (i_op == ALU_ADD): o_result = i_a + i_b;
      (i_op == ALU_SUB): o_result = w_diff;
      (i_op == ALU_AND): o_result = i_a & i_b;
      (i_op == ALU_OR):  o_result = i_a | i_b;
      (i_op == ALU_SLT): o_result = {31'd0, w_slt};
      default:           o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// EX stage: ALU, branch resolve, 2-instruction squash shadow, EX/MEM register.
// Define FORWARD_EN to forward operands from M (ALUResultM) and W (ResultW).
module execute_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_ExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] w_src_a;
  logic [31:0] w_rs2_val;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic        w_shadow;
  logic        w_taken;

  logic [1:0]  r_squash;
  logic        r_reg_write_m;
  logic        r_mem_write_m;
  logic        r_result_src_m;
  logic [4:0]  r_rd_m;
  logic [31:0] r_alu_result_m;
  logic [31:0] r_write_data_m;
  logic [31:0] r_pc_plus4_m;

`ifdef FORWARD_EN
  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;

  assign w_fwd_a = fwd_select(RS1_E, r_reg_write_m, r_rd_m,
                              r_result_src_m, RegWriteW, RDW);
  assign w_fwd_b = fwd_select(RS2_E, r_reg_write_m, r_rd_m,
                              r_result_src_m, RegWriteW, RDW);
  assign w_src_a   = fwd_mux(w_fwd_a, RD1_E, r_alu_result_m, ResultW);
  assign w_rs2_val = fwd_mux(w_fwd_b, RD2_E, r_alu_result_m, ResultW);
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{RS1_E, RS2_E, RegWriteW, RDW, ResultW};
  assign w_src_a      = RD1_E;
  assign w_rs2_val    = RD2_E;
`endif

  assign w_src_b = ALUSrcE ? Imm_ExtE : w_rs2_val;

  alu u_alu (
    .i_a      (w_src_a),
    .i_b      (w_src_b),
    .i_op     (ALUControlE),
    .o_result (w_alu_result),
    .o_zero   (w_zero)
  );

  // A branch inside the shadow is itself being squashed, so it is ignored.
  assign w_shadow  = (r_squash != 2'd0);
  assign w_taken   = BranchE & w_zero & ~w_shadow;
  assign PCSrcE    = w_taken;
  assign PCTargetE = PCE + Imm_ExtE;

  always_ff @(posedge clk) begin
    if (rst)
      r_squash <= 2'd0;
    else if (w_taken)
      r_squash <= SQUASH_LEN;
    else if (w_shadow)
      r_squash <= r_squash - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= 1'b0;
      r_rd_m         <= 5'd0;
      r_alu_result_m <= 32'd0;
      r_write_data_m <= 32'd0;
      r_pc_plus4_m   <= 32'd0;
    end else begin
      r_reg_write_m  <= RegWriteE & ~w_shadow;
      r_mem_write_m  <= MemWriteE & ~w_shadow;
      r_result_src_m <= ResultSrcE;
      r_rd_m         <= RD_E;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_rs2_val;
      r_pc_plus4_m   <= PCPlus4E;
    end
  end

  assign RegWriteM  = r_reg_write_m;
  assign MemWriteM  = r_mem_write_m;
  assign ResultSrcM = r_result_src_m;
  assign RD_M       = r_rd_m;
  assign ALUResultM = r_alu_result_m;
  assign WriteDataM = r_write_data_m;
  assign PCPlus4M   = r_pc_plus4_m;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed table, sequences, random vs model.
// Forwarding checks are compiled in when FORWARD_EN is defined.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E;
  logic [4:0]  RD_E, RS1_E, RS2_E;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_ExtE(Imm_ExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  typedef struct {
    logic        rst;
    logic        regw, alusrc, memw, ressrc, br;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rd, rs1, rs2;
    logic        regww;
    logic [4:0]  rdw;
    logic [31:0] resw;
  } in_t;

  typedef struct {
    in_t         i;
    logic        pcsrc;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic [4:0]  rdm;
    logic        regwm, memwm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(
    input logic rr, input logic [2:0] op,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] imm, input logic [31:0] pc,
    input logic regw, input logic memw, input logic alusrc,
    input logic br, input logic [4:0] rd);
    in_t t;
    t.rst = rr; t.op = op; t.rd1 = a; t.rd2 = b; t.imm = imm;
    t.pc = pc; t.regw = regw; t.memw = memw; t.alusrc = alusrc;
    t.br = br; t.rd = rd; t.ressrc = 1'b0;
    t.rs1 = 5'd0; t.rs2 = 5'd0; t.regww = 1'b0;
    t.rdw = 5'd0; t.resw = 32'd0;
    return t;
  endfunction

  function automatic vec_t vv(input in_t i, input logic pcsrc,
    input logic [31:0] tgt, input logic [31:0] alu,
    input logic [4:0] rdm, input logic regwm, input logic memwm);
    vec_t x;
    x.i = i; x.pcsrc = pcsrc; x.tgt = tgt; x.alu = alu;
    x.rdm = rdm; x.regwm = regwm; x.memwm = memwm;
    return x;
  endfunction

  // Drive at the falling edge; leave time for combinational checks.
  task automatic drive(input in_t t);
    @(negedge clk);
    rst = t.rst; RegWriteE = t.regw; ALUSrcE = t.alusrc;
    MemWriteE = t.memw; ResultSrcE = t.ressrc; BranchE = t.br;
    ALUControlE = t.op; RD1_E = t.rd1; RD2_E = t.rd2;
    Imm_ExtE = t.imm; PCE = t.pc; PCPlus4E = t.pc + 32'd4;
    RD_E = t.rd; RS1_E = t.rs1; RS2_E = t.rs2;
    RegWriteW = t.regww; RDW = t.rdw; ResultW = t.resw;
    #2;
  endtask

  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference model state, tracked at instruction level.
  int          m_cyc;
  int          m_last;
  logic        m_regw;
  logic [4:0]  m_rd;
  logic        m_ressrc;
  logic [31:0] m_alu;

  function automatic logic [31:0] opnd(input logic [4:0] rs,
    input logic [31:0] rf, input in_t t);
`ifdef FORWARD_EN
    if (m_regw && !m_ressrc && rs != 5'd0 && m_rd == rs) return m_alu;
    if (t.regww && rs != 5'd0 && t.rdw == rs) return t.resw;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op,
    input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  vec_t tbl[18];
  in_t  t;

  initial begin
    tbl[0]  = vv(mk(0,3'd0,5,7,0,0,1,0,0,0,3), 0,0, 12,3,1,0);
    tbl[1]  = vv(mk(0,3'd1,9,9,32'h20,32'h100,0,0,0,1,0),
                 1,32'h120, 0,0,0,0);
    tbl[2]  = vv(mk(0,3'd0,1,2,0,0,1,1,0,0,4), 0,0, 3,4,0,0);
    tbl[3]  = vv(mk(0,3'd1,9,9,8,32'h200,1,0,0,1,5),
                 0,32'h208, 0,5,0,0);
    tbl[4]  = vv(mk(0,3'd0,10,20,0,0,1,1,0,0,6), 0,0, 30,6,1,1);
    tbl[5]  = vv(mk(0,3'd5,32'hFFFF_FFFF,1,32'h20,32'hFFFF_FFF0,
                    1,0,0,0,7), 0,32'h10, 1,7,1,0);
    tbl[6]  = vv(mk(0,3'd2,32'hF0F0,32'hFF00,0,0,1,0,0,0,8),
                 0,0, 32'hF000,8,1,0);
    tbl[7]  = vv(mk(0,3'd3,32'hF0F0,32'h0F00,0,0,1,0,0,0,9),
                 0,0, 32'hFFF0,9,1,0);
    tbl[8]  = vv(mk(0,3'd7,5,3,0,0,1,0,0,0,10), 0,0, 0,10,1,0);
    tbl[9]  = vv(mk(0,3'd0,100,9999,32'h23,0,1,0,1,0,1),
                 0,32'h23, 135,1,1,0);
    tbl[10] = vv(mk(0,3'd1,3,3,32'h10,32'h40,1,0,0,1,11),
                 1,32'h50, 0,11,1,0);
    tbl[11] = vv(mk(0,3'd0,1,1,0,0,1,1,0,0,12), 0,0, 2,12,0,0);
    tbl[12] = vv(mk(0,3'd1,4,4,0,0,1,0,0,1,13), 0,0, 0,13,0,0);
    tbl[13] = vv(mk(1,3'd1,4,4,4,32'h300,1,0,0,1,14),
                 1,32'h304, 0,0,0,0);
    tbl[14] = vv(mk(0,3'd0,2,2,0,0,1,1,0,0,15), 0,0, 4,15,1,1);
    tbl[15] = vv(mk(0,3'd1,6,6,8,0,0,0,0,1,0), 1,8, 0,0,0,0);
    tbl[16] = vv(mk(1,3'd0,1,2,0,0,1,0,0,0,16), 0,0, 0,0,0,0);
    tbl[17] = vv(mk(0,3'd0,7,8,0,0,1,1,0,0,17), 0,0, 15,17,1,1);

    // Reset state
    t = mk(1,3'd0,32'h55,32'h66,32'h77,32'h88,1,1,0,0,5);
    t.ressrc = 1'b1;
    drive(t);
    to_edge();
    drive(t);
    to_edge();
    chk("rst RegWriteM",  {31'd0, RegWriteM},  32'd0);
    chk("rst MemWriteM",  {31'd0, MemWriteM},  32'd0);
    chk("rst ResultSrcM", {31'd0, ResultSrcM}, 32'd0);
    chk("rst RD_M",       {27'd0, RD_M},       32'd0);
    chk("rst ALUResultM", ALUResultM, 32'd0);
    chk("rst WriteDataM", WriteDataM, 32'd0);
    chk("rst PCPlus4M",   PCPlus4M,   32'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      chk($sformatf("t%0d PCSrcE", k), {31'd0, PCSrcE},
          {31'd0, tbl[k].pcsrc});
      chk($sformatf("t%0d PCTargetE", k), PCTargetE, tbl[k].tgt);
      to_edge();
      chk($sformatf("t%0d ALUResultM", k), ALUResultM, tbl[k].alu);
      chk($sformatf("t%0d RD_M", k), {27'd0, RD_M},
          {27'd0, tbl[k].rdm});
      chk($sformatf("t%0d RegWriteM", k), {31'd0, RegWriteM},
          {31'd0, tbl[k].regwm});
      chk($sformatf("t%0d MemWriteM", k), {31'd0, MemWriteM},
          {31'd0, tbl[k].memwm});
      chk($sformatf("t%0d WriteDataM", k), WriteDataM,
          tbl[k].i.rst ? 32'd0 : tbl[k].i.rd2);
      chk($sformatf("t%0d PCPlus4M", k), PCPlus4M,
          tbl[k].i.rst ? 32'd0 : tbl[k].i.pc + 32'd4);
    end

`ifdef FORWARD_EN
    drive(mk(1,3'd0,0,0,0,0,0,0,0,0,0));
    to_edge();
    drive(mk(0,3'd0,32'h10,0,0,0,1,0,0,0,5));
    to_edge();
    t = mk(0,3'd0,0,1,0,0,1,0,0,0,6);
    t.rs1 = 5'd5; t.regww = 1'b1; t.rdw = 5'd5; t.resw = 32'h20;
    drive(t);
    to_edge();
    chk("fwd M priority", ALUResultM, 32'h11);
    t.rd = 5'd0;
    drive(t);
    to_edge();
    chk("fwd W used", ALUResultM, 32'h21);
    t = mk(0,3'd0,7,1,0,0,1,0,0,0,0);
    t.regww = 1'b1; t.rdw = 5'd0; t.resw = 32'h20;
    drive(t);
    to_edge();
    chk("fwd x0 reg value", ALUResultM, 32'h8);
`endif

    // Random stimulus against the instruction-level model
    m_cyc = 0; m_last = -100;
    m_regw = 1'b0; m_rd = 5'd0; m_ressrc = 1'b0; m_alu = 32'd0;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, b2, b, exp_alu;
      logic        shadow, taken;
      t.rst    = (k == 0) || ($urandom_range(0, 19) == 0);
      t.br     = ($urandom_range(0, 2) == 0);
      t.op     = t.br ? 3'd1 : 3'($urandom_range(0, 7));
      t.alusrc = t.br ? 1'b0 : 1'($urandom_range(0, 1));
      t.rd1    = ($urandom_range(0, 1) == 1) ? $urandom
                                              : 32'($urandom_range(0, 3));
      t.rd2    = ($urandom_range(0, 1) == 1) ? t.rd1 : $urandom;
      t.imm    = $urandom;
      t.pc     = $urandom;
      t.regw   = 1'($urandom_range(0, 1));
      t.memw   = 1'($urandom_range(0, 1));
      t.ressrc = 1'($urandom_range(0, 1));
      t.rd     = 5'($urandom_range(0, 3));
      t.rs1    = 5'($urandom_range(0, 3));
      t.rs2    = 5'($urandom_range(0, 3));
      t.regww  = 1'($urandom_range(0, 1));
      t.rdw    = 5'($urandom_range(0, 3));
      t.resw   = $urandom;

      a       = opnd(t.rs1, t.rd1, t);
      b2      = opnd(t.rs2, t.rd2, t);
      b       = t.alusrc ? t.imm : b2;
      exp_alu = ref_alu(t.op, a, b);
      shadow  = (m_cyc - m_last == 1) || (m_cyc - m_last == 2);
      taken   = t.br && (a == b) && !shadow;

      drive(t);
      chk("rnd PCSrcE", {31'd0, PCSrcE}, {31'd0, taken});
      chk("rnd PCTargetE", PCTargetE, t.pc + t.imm);
      to_edge();
      if (t.rst) begin
        m_last = -100;
        m_regw = 1'b0; m_rd = 5'd0; m_ressrc = 1'b0; m_alu = 32'd0;
        chk("rnd rst ALUResultM", ALUResultM, 32'd0);
        chk("rnd rst WriteDataM", WriteDataM, 32'd0);
        chk("rnd rst PCPlus4M", PCPlus4M, 32'd0);
      end else begin
        if (taken) m_last = m_cyc;
        m_regw = t.regw && !shadow;
        m_rd = t.rd; m_ressrc = t.ressrc; m_alu = exp_alu;
        chk("rnd ALUResultM", ALUResultM, exp_alu);
        chk("rnd WriteDataM", WriteDataM, b2);
        chk("rnd PCPlus4M", PCPlus4M, t.pc + 32'd4);
      end
      chk("rnd RegWriteM", {31'd0, RegWriteM}, {31'd0, m_regw});
      chk("rnd MemWriteM", {31'd0, MemWriteM},
          {31'd0, !t.rst && t.memw && !shadow});
      chk("rnd ResultSrcM", {31'd0, ResultSrcM}, {31'd0, m_ressrc});
      chk("rnd RD_M", {27'd0, RD_M}, {27'd0, m_rd});
      m_cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
